data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Parametrised successor to the core's single-port data memory.
- Adds a valid/ready request channel, byte-write enables and a configurable read latency.
- Adds response back-pressure, out-of-range detection and an optional post-reset clear sequencer.
- Sits between the load/store unit and storage; one request accepted per cycle, responses returned strictly in order.

Parameters:
- DATA_W, default REG_SIZE (32): word width in bits; must be a multiple of 8.
- DEPTH, default ADDRESS_SPACE_W: number of words.
- ADDR_W, default REG_SIZE: request address width; word-addressed.
- RD_LAT, default 1: response latency in cycles from acceptance; legal 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte-write enables (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_we  out  1  echoes req_we of the request.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- rsp_err  out  1  request address >= DEPTH.

Behaviour:
- Reset (async assert, sync deassert):
  - rsp_valid=0, rsp_we=0, rsp_rdata=0, rsp_err=0.
  - All pipeline valid bits cleared; in-flight responses discarded.
  - Memory array not reset (see optional feature). Writes already committed persist.
- Pipeline and stall:
  - RD_LAT stages, each holding {valid, we, err, data}. The last stage drives the rsp_* outputs.
  - stall = rsp_valid && !rsp_ready. When stalled, all stages hold and req_ready=0.
  - When not stalled, all stages shift one place and req_ready=1 (state RUN only).
- Latency: a request accepted in cycle N presents its response in cycle N+RD_LAT, plus any cycles stalled.
- Read:
  - Array sampled in the acceptance cycle.
  - A write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- Write:
  - Commits in the acceptance cycle. Byte i is updated iff req_be[i].
  - req_be=0 is legal: no change, response still generated.
  - Every write yields exactly one response with rsp_we=1 and rsp_rdata=0.
- Out of range (req_addr >= DEPTH):
  - No array access; the write is dropped.
  - Response has rsp_err=1, rsp_rdata=0.
  - No wrap-around: the address is never truncated modulo DEPTH.
- Idle cycles (no acceptance) insert bubbles (valid=0) into the pipeline.
- Response ordering equals acceptance order; no reordering, no duplication.
- Simultaneous accept and consume in the same cycle is allowed, giving full throughput of one request per cycle.
- State machine:
  - States: INIT, RUN.
  - Without the optional feature, reset enters RUN directly.

Optional Feature:
- Macro: DATA_MEM_CLEAR_EN.
- Defined:
  - Reset enters INIT with a clear counter at 0 and req_ready=0.
  - Each cycle in INIT writes word[cnt]=0 and increments cnt.
  - After writing DEPTH-1, the block moves to RUN on the next cycle. Clearing takes DEPTH cycles.
  - rst asserted mid-clear restarts from address 0.
  - rsp_valid stays 0 throughout INIT.
- Undefined:
  - No INIT state and no counter; the block is ready the first cycle after reset.
  - Array contents are undefined until written (X in simulation).

Decomposition:
- Shared package data_mem_pkg holds:
  - typedef data_mem_state_e {INIT, RUN};
  - typedef struct data_mem_rsp_t {valid, we, err, data};
  - localparam RD_LAT_MAX = 4.
- REG_SIZE and ADDRESS_SPACE_W continue to come from the ISA constants header.
- Sub-module data_mem_pipe: RD_LAT-deep shift register of data_mem_rsp_t with a common hold enable and async clear. It carries no storage or address logic.

Test Plan:
- RD_LAT=2, rsp_ready=1:
  - Write addr 5 data 0xDEADBEEF be=4'hF, then read addr 5 next cycle.
  - Expect: write response (rsp_we=1, rdata=0) two cycles after its accept; read response rdata=0xDEADBEEF two cycles after its accept.
- Byte enables:
  - Write 0x11223344 to addr 3 with be=F, then 0xAABBCCDD with be=4'b0101, then read addr 3.
  - Expect rdata=0x11BB33DD.
- Back-pressure:
  - Hold rsp_ready=0 while issuing 3 reads (addr 0,1,2 holding 0xA,0xB,0xC); req_ready drops once rsp_valid=1.
  - Release rsp_ready: responses 0xA, 0xB, 0xC in order, none lost or duplicated.
- Out of range:
  - DEPTH=16: write addr 16 data 0x5, then read addr 0.
  - Expect the first response rsp_err=1, rdata=0, and addr 0 unchanged (no wrap).
- Reset mid-operation:
  - Assert rst with 2 reads in flight.
  - Expect rsp_valid=0 immediately (async), no stale responses after release, and the earlier committed write still readable.
- DATA_MEM_CLEAR_EN, DEPTH=16:
  - Expect req_ready=0 for 16 cycles after reset, then 1; a read of addr 7 returns 0.
  - Re-asserting rst at cycle 8 of the clear restarts the full 16-cycle count.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data_mem block and its response pipeline.
package data_mem_pkg;

    // ISA-wide constants: register width and the default data-memory depth in words.
    localparam int REG_SIZE        = 32;
    localparam int ADDRESS_SPACE_W = 256;

    localparam int RD_LAT_MAX = 4;

    typedef enum logic {
        INIT,
        RUN
    } data_mem_state_e;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic                err;
        logic [REG_SIZE-1:0] data;
    } data_mem_rsp_t;

endpackage

// File: rtl/data_mem_pipe.sv
// RD_LAT-deep response shift register with a common hold enable and async clear.
module data_mem_pipe
    import data_mem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold_i,
    input  data_mem_rsp_t in_i,
    output data_mem_rsp_t out_o
);

    data_mem_rsp_t stage_q [RD_LAT];

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its predecessor's pre-edge value and the shift happens in one step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else if (!hold_i) begin
            stage_q[0] <= in_i;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/data_mem.sv
// Word-addressed data memory with valid/ready request and response channels,
// byte enables and RD_LAT-cycle latency. Define DATA_MEM_CLEAR_EN to zero the array after reset.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DATA_W = REG_SIZE,
    parameter int DEPTH  = ADDRESS_SPACE_W,
    parameter int ADDR_W = REG_SIZE,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if ((DATA_W % 8) != 0 || DATA_W > REG_SIZE || RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_param
            $error("data_mem: illegal DATA_W/RD_LAT parameter combination");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [DEPTH];

    data_mem_state_e   state;
    logic              stall;
    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_idx;
    data_mem_rsp_t     pipe_in;
    data_mem_rsp_t     pipe_out;

`ifdef DATA_MEM_CLEAR_EN
    data_mem_state_e  state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    assign state   = state_q;
    assign clr_we  = (state_q == INIT);
    assign clr_idx = cnt_q;
`else
    assign state   = RUN;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
`endif

    // A stalled response freezes the whole pipeline, so nothing new may enter.
    assign stall     = pipe_out.valid && !rsp_ready;
    assign req_ready = (state == RUN) && !stall;
    assign accept    = req_valid && req_ready;

    // Full-width compare: an out-of-range address must never alias onto a low word.
    assign in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
    assign idx      = req_addr[IDX_W-1:0];

    // NOTE: the array is deliberately left out of reset; only the optional
    // clear sequencer initialises it, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_idx] <= '0;
        end else if (accept && req_we && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    mem_q[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    // NOTE: pipe_in is fully defaulted before any branch, so no latch can be inferred.
    always_comb begin
        pipe_in = '0;
        if (accept) begin
            pipe_in.valid = 1'b1;
            pipe_in.we    = req_we;
            pipe_in.err   = !in_range;
            if (!req_we && in_range) begin
                pipe_in.data = REG_SIZE'(mem_q[idx]);
            end
        end
    end

    data_mem_pipe #(
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .hold_i (stall),
        .in_i   (pipe_in),
        .out_o  (pipe_out)
    );

    assign rsp_valid = pipe_out.valid;
    assign rsp_we    = pipe_out.we;
    assign rsp_err   = pipe_out.err;
    assign rsp_rdata = pipe_out.data[DATA_W-1:0];

endmodule

// File: tb/tb_data_mem.sv
// Directed testbench for data_mem (DEPTH=16, RD_LAT=2); inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_data_mem;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;
    localparam int RD_LAT = 2;
`ifdef DATA_MEM_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif
    localparam int          INIT_CYCLES = CLEAR_EN ? DEPTH : 0;
    localparam logic [31:0] EXP_PERSIST5 = CLEAR_EN ? 32'h0 : 32'hDEADBEEF;
    localparam logic [31:0] EXP_PERSIST3 = CLEAR_EN ? 32'h0 : 32'h11BB33DD;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic we,
                             input logic err, input logic [31:0] data);
        check1({tag, ".valid"}, rsp_valid, v);
        check1({tag, ".we"},    rsp_we,    we);
        check1({tag, ".err"},   rsp_err,   err);
        check32({tag, ".rdata"}, rsp_rdata, data);
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
    endtask

    task automatic drive_idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Deassert reset on a falling edge and count the cycles until the block accepts requests.
    task automatic release_reset(input string tag);
        int waited;
        waited = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        while (!req_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check32({tag, ".init_cycles"}, 32'(waited), 32'(INIT_CYCLES));
    endtask

    initial begin
        drive_idle();
        rsp_ready = 1'b1;
        rst       = 1'b1;
        #1;
        check_rsp("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        release_reset("reset");
        check1("reset.req_ready", req_ready, 1'b1);

`ifdef DATA_MEM_CLEAR_EN
        drive_req(1'b0, 7, 32'h0, 4'h0); cyc();
        drive_idle(); cyc();
        check_rsp("clr.rd7", 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check1("clr.mid_busy", req_ready, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        release_reset("clr_restart");
`endif

        // Write then read back-to-back, full response latency.
        drive_req(1'b1, 5, 32'hDEADBEEF, 4'hF); cyc();
        check1("wr5.latency", rsp_valid, 1'b0);
        drive_req(1'b0, 5, 32'h0, 4'h0); cyc();
        check_rsp("wr5.rsp", 1'b1, 1'b1, 1'b0, 32'h0);
        drive_idle(); cyc();
        check_rsp("rd5.rsp", 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        cyc();
        check1("rd5.drained", rsp_valid, 1'b0);

        // Byte enables: 0x11223344 merged with 0xAABBCCDD under be=0101.
        drive_req(1'b1, 3, 32'h11223344, 4'hF); cyc();
        drive_req(1'b1, 3, 32'hAABBCCDD, 4'b0101); cyc();
        check_rsp("be.wr_full", 1'b1, 1'b1, 1'b0, 32'h0);
        drive_req(1'b0, 3, 32'h0, 4'h0); cyc();
        check_rsp("be.wr_part", 1'b1, 1'b1, 1'b0, 32'h0);
        drive_idle(); cyc();
        check_rsp("be.rd", 1'b1, 1'b0, 1'b0, 32'h11BB33DD);
        cyc();

        // Preload addr 0..2 for the back-pressure run.
        drive_req(1'b1, 0, 32'hA, 4'hF); cyc();
        drive_req(1'b1, 1, 32'hB, 4'hF); cyc();
        drive_req(1'b1, 2, 32'hC, 4'hF); cyc();
        drive_idle(); cyc(); cyc(); cyc();
        check1("preload.drained", rsp_valid, 1'b0);

        // Back-pressure: responses hold and the request side stalls.
        rsp_ready = 1'b0;
        drive_req(1'b0, 0, 32'h0, 4'h0); cyc();
        check1("bp.ready_empty", req_ready, 1'b1);
        drive_req(1'b0, 1, 32'h0, 4'h0); cyc();
        check1("bp.ready_drop", req_ready, 1'b0);
        check_rsp("bp.hold0", 1'b1, 1'b0, 1'b0, 32'hA);
        drive_req(1'b0, 2, 32'h0, 4'h0); cyc();
        check1("bp.still_stalled", req_ready, 1'b0);
        cyc();
        check_rsp("bp.hold2", 1'b1, 1'b0, 1'b0, 32'hA);
        rsp_ready = 1'b1;
        #1;
        check1("bp.ready_release", req_ready, 1'b1);
        cyc();
        drive_idle();
        check_rsp("bp.rsp1", 1'b1, 1'b0, 1'b0, 32'hB);
        cyc();
        check_rsp("bp.rsp2", 1'b1, 1'b0, 1'b0, 32'hC);
        cyc();
        check1("bp.no_dup", rsp_valid, 1'b0);

        // Out of range: no wrap onto addr 0.
        drive_req(1'b1, 16, 32'h5, 4'hF); cyc();
        drive_req(1'b0, 0, 32'h0, 4'h0); cyc();
        check_rsp("oor.wr16", 1'b1, 1'b1, 1'b1, 32'h0);
        drive_req(1'b0, 16, 32'h0, 4'h0); cyc();
        check_rsp("oor.rd0", 1'b1, 1'b0, 1'b0, 32'hA);
        drive_req(1'b0, 32'h0001_0000, 32'h0, 4'h0); cyc();
        check_rsp("oor.rd16", 1'b1, 1'b0, 1'b1, 32'h0);
        drive_idle(); cyc();
        check_rsp("oor.rd_big", 1'b1, 1'b0, 1'b1, 32'h0);
        cyc();

        // Reset with two reads in flight.
        drive_req(1'b0, 3, 32'h0, 4'h0); cyc();
        drive_req(1'b0, 5, 32'h0, 4'h0); cyc();
        drive_idle();
        check1("rst.inflight", rsp_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_rsp("rst.async", 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        release_reset("rst_mid");
        repeat (3) begin
            cyc();
            check1("rst.no_stale", rsp_valid, 1'b0);
        end
        drive_req(1'b0, 5, 32'h0, 4'h0); cyc();
        drive_req(1'b0, 3, 32'h0, 4'h0); cyc();
        drive_idle();
        check_rsp("rst.persist5", 1'b1, 1'b0, 1'b0, EXP_PERSIST5);
        cyc();
        check_rsp("rst.persist3", 1'b1, 1'b0, 1'b0, EXP_PERSIST3);
        cyc();
        check1("rst.drained", rsp_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
